pipe_skid_reg: RTL and testbench

Parametrised, elastic pipeline register: DEPTH chained stages, each holding a WIDTH-bit payload with a valid/ready handshake and a one-entry skid buffer, so the chain sustains one transfer per cycle while every ready is registered. Adds synchronous flush and an occupancy count, which the plain resettable flip-flop lacks. It is the stage register between fetch/decode/execute/memory/writeback in the pipelined processor, where hazard stalls arrive as deasserted ready and branch mispredicts as flush.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_skid_reg_stage.sv | 91 +++++++++
 rtl/pipe_skid_reg.sv | 73 +++++++
 tb/tb_pipe_skid_reg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_pkg : shared types and sizing helpers for the elastic pipeline register
// Revision : 1.0
// ----------------------------------------------------------------------------
package pipe_pkg;

  // Stage state as seen through {s_valid, m_valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } stage_state_t;

  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_reg_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// skid_stage : one valid/ready register slice with a single-entry skid buffer
// Revision   : 1.0
// ----------------------------------------------------------------------------
module skid_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             m_valid,
  output logic             s_valid
);

  localparam logic [1:0] ST_EMPTY = EMPTY;
  localparam logic [1:0] ST_ONE   = ONE;
  localparam logic [1:0] ST_FULL  = FULL;

  logic             r_m_valid;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_m_data;
  logic [WIDTH-1:0] r_s_data;

  logic             w_accept;
  logic             w_consume;
  logic [1:0]       w_state;

  assign w_accept  = in_valid & ~r_s_valid;
  assign w_consume = r_m_valid & out_ready;
  assign w_state   = {r_s_valid, r_m_valid};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= RESET_VAL;
      r_s_data  <= RESET_VAL;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else begin
      case (w_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
          end
        end
        ST_ONE: begin
          if (w_accept && w_consume) begin
            r_m_data <= in_data;
          end else if (w_accept) begin
            r_s_valid <= 1'b1;
            r_s_data  <= in_data;
          end else if (w_consume) begin
            r_m_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // Skid entry is older than anything upstream, so it refills main.
          if (w_consume) begin
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
          end
        end
        default: begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ~r_s_valid;
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;
  assign m_valid   = r_m_valid;
  assign s_valid   = r_s_valid;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_skid_reg : DEPTH chained skid stages with flush and occupancy count
// Revision      : 1.0
// ----------------------------------------------------------------------------
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  input  logic                      out_ready,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int OCC_W = occ_w(DEPTH);

  // Index k is the link feeding stage k; index DEPTH is the chain output.
  logic [DEPTH:0]   w_valid;
  logic [DEPTH:0]   w_ready;
  logic [WIDTH-1:0] w_data [0:DEPTH];
  logic [DEPTH-1:0] w_mv;
  logic [DEPTH-1:0] w_sv;
  logic [OCC_W-1:0] w_occ;

  assign w_valid[0]     = in_valid;
  assign w_data[0]      = in_data;
  assign in_ready       = w_ready[0];
  assign w_ready[DEPTH] = out_ready;
  assign out_valid      = w_valid[DEPTH];
  assign out_data       = w_data[DEPTH];

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      skid_stage #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_stage (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (w_valid[k]),
        .in_data   (w_data[k]),
        .in_ready  (w_ready[k]),
        .out_valid (w_valid[k+1]),
        .out_data  (w_data[k+1]),
        .out_ready (w_ready[k+1]),
        .m_valid   (w_mv[k]),
        .s_valid   (w_sv[k])
      );
    end
  endgenerate

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ = w_occ + OCC_W'(w_mv[i]) + OCC_W'(w_sv[i]);
    end
  end

  assign occupancy = w_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_skid_reg : directed and randomized checks of pipe_skid_reg, DEPTH 1..4
// Revision         : 1.0
// ----------------------------------------------------------------------------
module tb_pipe_skid_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        fl1, v1, r1, ir1, ov1;
  logic [7:0]  d1, od1;
  logic [1:0]  oc1;
  logic        fl2, v2, r2, ir2, ov2;
  logic [7:0]  d2, od2;
  logic [2:0]  oc2;
  logic        fl3, v3, r3, ir3, ov3;
  logic [7:0]  d3, od3;
  logic [2:0]  oc3;
  logic        fl4, v4, r4, ir4, ov4;
  logic [15:0] d4, od4;
  logic [3:0]  oc4;

  pipe_skid_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) u1 (
    .clk(clk), .reset(reset), .flush(fl1), .in_valid(v1), .in_data(d1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_ready(r1), .occupancy(oc1));
  pipe_skid_reg #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'h3C)) u2 (
    .clk(clk), .reset(reset), .flush(fl2), .in_valid(v2), .in_data(d2), .in_ready(ir2),
    .out_valid(ov2), .out_data(od2), .out_ready(r2), .occupancy(oc2));
  pipe_skid_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hC3)) u3 (
    .clk(clk), .reset(reset), .flush(fl3), .in_valid(v3), .in_data(d3), .in_ready(ir3),
    .out_valid(ov3), .out_data(od3), .out_ready(r3), .occupancy(oc3));
  pipe_skid_reg #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'hBEEF)) u4 (
    .clk(clk), .reset(reset), .flush(fl4), .in_valid(v4), .in_data(d4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_ready(r4), .occupancy(oc4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  got[$];
    logic [7:0]  exp3 [3];
    logic [15:0] model[$];
    logic        acc, cons, seen;
    int          nxt;

    reset = 1'b1;
    {fl1, v1, r1, d1} = '0;
    {fl2, v2, r2, d2} = '0;
    {fl3, v3, r3, d3} = '0;
    {fl4, v4, r4, d4} = '0;
    // Offers during reset must not be captured.
    v1 = 1'b1; d1 = 8'hEE;
    v3 = 1'b1; d3 = 8'hEE;
    repeat (3) step();
    reset = 1'b0;
    v1 = 1'b0; v3 = 1'b0;

    chk("rst_in_ready", ir3, 1'b1);
    chk("rst_out_valid", ov3, 1'b0);
    chk("rst_out_data", od3, 8'hC3);
    chk("rst_occ", oc3, 3'd0);
    chk("rst_out_data_d1", od1, 8'h5A);
    chk("rst_out_data_d4", od4, 16'hBEEF);
    repeat (3) step();
    chk("idle_out_valid", ov3, 1'b0);
    chk("idle_occ", oc3, 3'd0);
    chk("idle_occ_d1", oc1, 2'd0);

    // DEPTH=3 stream: value j accepted at edge j is visible after edge j+2.
    r3 = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      v3 = (e <= 16);
      d3 = 8'(e);
      if (e <= 16) chk("stream_in_ready", ir3, 1'b1);
      step();
      chk("stream_out_valid", ov3, (e >= 3 && e <= 18));
      if (e >= 3 && e <= 18) chk("stream_out_data", od3, 8'(e - 2));
    end
    v3 = 1'b0;

    // DEPTH=1 stall: two entries fit, third held off.
    r1 = 1'b0; v1 = 1'b1; d1 = 8'hA1;
    chk("stall_ready0", ir1, 1'b1);
    step();
    chk("stall_occ1", oc1, 2'd1);
    d1 = 8'hA2;
    chk("stall_ready1", ir1, 1'b1);
    step();
    chk("stall_occ2", oc1, 2'd2);
    chk("stall_ready_low", ir1, 1'b0);
    d1 = 8'hA3;
    repeat (2) step();
    chk("stall_occ_hold", oc1, 2'd2);
    chk("stall_head", od1, 8'hA1);
    chk("stall_ready_hold", ir1, 1'b0);
    r1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (ov1) got.push_back(od1);
      acc = v1 && ir1;
      step();
      if (acc) v1 = 1'b0;
    end
    exp3[0] = 8'hA1; exp3[1] = 8'hA2; exp3[2] = 8'hA3;
    chk("stall_count", got.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("stall_order", (i < got.size()) ? got[i] : 8'h00, exp3[i]);
    chk("stall_drained", oc1, 2'd0);

    // DEPTH=2 fill to capacity, then flush with a live offer.
    r2 = 1'b0; nxt = 0;
    for (int c = 0; c < 20 && nxt < 4; c++) begin
      v2 = 1'b1;
      d2 = 8'(8'hB1 + nxt);
      acc = ir2;
      step();
      if (acc) nxt++;
    end
    v2 = 1'b0;
    chk("fill_count", nxt, 4);
    chk("fill_occ", oc2, 3'd4);
    chk("fill_ready", ir2, 1'b0);
    fl2 = 1'b1; v2 = 1'b1; d2 = 8'hFF;
    step();
    fl2 = 1'b0; v2 = 1'b0;
    chk("flush_occ", oc2, 3'd0);
    chk("flush_out_valid", ov2, 1'b0);
    chk("flush_ready", ir2, 1'b1);
    r2 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      chk("flush_no_output", ov2, 1'b0);
      step();
    end
    v2 = 1'b1; d2 = 8'hC1;
    step();
    v2 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (ov2 && !seen) begin
        chk("post_flush_data", od2, 8'hC1);
        seen = 1'b1;
      end
      step();
    end
    chk("post_flush_seen", seen, 1'b1);

    // Reset and flush together while DEPTH=1 is full.
    r1 = 1'b0; v1 = 1'b1; d1 = 8'hD1;
    step();
    d1 = 8'hD2;
    step();
    v1 = 1'b0;
    chk("prio_full", oc1, 2'd2);
    reset = 1'b1; fl1 = 1'b1; v1 = 1'b1; d1 = 8'hE7;
    step();
    reset = 1'b0; fl1 = 1'b0; v1 = 1'b0;
    chk("prio_data", od1, 8'h5A);
    chk("prio_occ", oc1, 2'd0);
    chk("prio_out_valid", ov1, 1'b0);
    chk("prio_ready", ir1, 1'b1);

    // DEPTH=4 random traffic against an in-flight queue.
    nxt = 0; v4 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      if (!v4) begin
        v4 = ($urandom % 4) != 0;
        d4 = 16'(nxt);
      end
      r4 = ($urandom % 3) != 0;
      chk("rnd_occ", oc4, model.size());
      chk("rnd_cap", (oc4 <= 4'd8), 1'b1);
      if (ov4) begin
        if (model.size() == 0) chk("rnd_dup", ov4, 1'b0);
        else chk("rnd_order", od4, model[0]);
      end
      acc  = v4 && ir4;
      cons = ov4 && r4;
      step();
      if (cons && model.size() != 0) void'(model.pop_front());
      if (acc) begin
        model.push_back(d4);
        nxt++;
        v4 = 1'b0;
      end
    end
    v4 = 1'b0; r4 = 1'b1;
    for (int c = 0; c < 40 && (ov4 || model.size() != 0); c++) begin
      if (ov4) begin
        if (model.size() == 0) chk("drain_dup", ov4, 1'b0);
        else chk("drain_order", od4, model[0]);
      end
      cons = ov4;
      step();
      if (cons && model.size() != 0) void'(model.pop_front());
    end
    chk("drain_empty", model.size(), 0);
    chk("drain_occ", oc4, 4'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
